// File: rtl/mig_request_adapter_if.sv
// Bundle of client request/response and MIG app_* signals for mig_request_adapter.
// master = adapter view, slave = client + MIG environment view.
interface mig_request_adapter_if #(
    parameter int unsigned ADDR_WIDTH = 27,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned MASK_WIDTH = 16
);
    logic                  init_calib_complete;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [MASK_WIDTH-1:0] req_wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  app_en;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic [2:0]            app_cmd;
    logic [ADDR_WIDTH-1:0] app_addr;
    logic [DATA_WIDTH-1:0] app_wdf_data;
    logic [MASK_WIDTH-1:0] app_wdf_mask;
    logic                  app_rdy;
    logic                  app_wdf_rdy;
    logic                  app_rd_data_valid;
    logic [DATA_WIDTH-1:0] app_rd_data;
    logic                  busy;
    logic                  err_sticky;

    modport master (
        input  init_calib_complete, req_valid, req_write, req_addr, req_wdata, req_wmask,
               rsp_ready, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
        output req_ready, rsp_valid, rsp_rdata, app_en, app_wdf_wren, app_wdf_end, app_cmd,
               app_addr, app_wdf_data, app_wdf_mask, busy, err_sticky
    );

    modport slave (
        output init_calib_complete, req_valid, req_write, req_addr, req_wdata, req_wmask,
               rsp_ready, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, app_en, app_wdf_wren, app_wdf_end, app_cmd,
               app_addr, app_wdf_data, app_wdf_mask, busy, err_sticky
    );
endinterface

// File: rtl/mig_request_adapter.sv
// Single-outstanding-request adapter onto the MIG app interface; read data returns in order
// through a show-ahead FIFO whose free space is reserved before each read is issued.
module mig_request_adapter #(
    parameter int unsigned ADDR_WIDTH = 27,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned MASK_WIDTH = 16,
    parameter int unsigned RD_DEPTH   = 8
) (
    input  logic                  MIG_Clk,
    input  logic                  Reset,
    mig_request_adapter_if.master bus
);
    localparam int unsigned PW = $clog2(RD_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {StCalib, StIdle, StWrite, StRead} state_e;

    state_e                state_q, state_d;
    logic                  req_ready_q, rsp_valid_q, busy_q, err_sticky_q;
    logic                  app_en_q, app_wdf_wren_q, app_wdf_end_q;
    logic [2:0]            app_cmd_q;
    logic [ADDR_WIDTH-1:0] app_addr_q;
    logic [DATA_WIDTH-1:0] app_wdf_data_q;
    logic [MASK_WIDTH-1:0] app_wdf_mask_q;
    logic                  cmd_done_q, data_done_q;
    logic [CW-1:0]         pending_q, pending_d, count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_q [RD_DEPTH];

    logic cmd_acc, data_acc, rd_issue, push, pop, credit;

    always_comb begin
        cmd_acc  = app_en_q & bus.app_rdy;
        data_acc = app_wdf_wren_q & bus.app_wdf_rdy;
        rd_issue = (state_q == StRead) & cmd_acc;
        // Beats with nothing outstanding are stray and never enter the FIFO.
        push     = bus.app_rd_data_valid & (pending_q != '0);
        pop      = rsp_valid_q & bus.rsp_ready;

        pending_d = pending_q;
        if (rd_issue && !push) begin
            pending_d = pending_q + 1'b1;
        end else if (!rd_issue && push) begin
            pending_d = pending_q - 1'b1;
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        credit = (SW'(pending_d) + SW'(count_d)) < SW'(RD_DEPTH);

        state_d = state_q;
        unique case (state_q)
            StCalib: if (bus.init_calib_complete) state_d = StIdle;
            StIdle:  if (bus.req_valid) state_d = bus.req_write ? StWrite : StRead;
            StWrite: if ((cmd_done_q | cmd_acc) && (data_done_q | data_acc)) state_d = StIdle;
            StRead:  if (cmd_acc) state_d = StIdle;
            default: state_d = StCalib;
        endcase
    end

    always_ff @(posedge MIG_Clk) begin
        if (Reset) begin
            state_q        <= StCalib;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            err_sticky_q   <= 1'b0;
            app_en_q       <= 1'b0;
            app_wdf_wren_q <= 1'b0;
            app_wdf_end_q  <= 1'b0;
            app_cmd_q      <= '0;
            app_addr_q     <= '0;
            app_wdf_data_q <= '0;
            app_wdf_mask_q <= '0;
            cmd_done_q     <= 1'b0;
            data_done_q    <= 1'b0;
            pending_q      <= '0;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == StIdle);
            busy_q      <= (state_d != StIdle) || (pending_d != '0);
            pending_q   <= pending_d;
            count_q     <= count_d;
            rsp_valid_q <= (count_d != '0);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (bus.app_rd_data_valid && pending_q == '0) err_sticky_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        app_addr_q     <= {bus.req_addr[ADDR_WIDTH-1:3], 3'b000};
                        app_cmd_q      <= bus.req_write ? 3'd0 : 3'd1;
                        app_wdf_data_q <= bus.req_wdata;
                        app_wdf_mask_q <= bus.req_wmask;
                        cmd_done_q     <= 1'b0;
                        data_done_q    <= 1'b0;
                        if (bus.req_write) begin
                            app_en_q       <= 1'b1;
                            app_wdf_wren_q <= 1'b1;
                            app_wdf_end_q  <= 1'b1;
                        end else begin
                            app_en_q <= credit;
                        end
                    end
                end
                StWrite: begin
                    if (cmd_acc) begin
                        app_en_q   <= 1'b0;
                        cmd_done_q <= 1'b1;
                    end
                    if (data_acc) begin
                        app_wdf_wren_q <= 1'b0;
                        app_wdf_end_q  <= 1'b0;
                        data_done_q    <= 1'b1;
                    end
                end
                StRead: begin
                    // Once raised, app_en stays up until MIG takes the command.
                    if (cmd_acc) begin
                        app_en_q <= 1'b0;
                    end else if (!app_en_q) begin
                        app_en_q <= credit;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge MIG_Clk) begin
        if (push) fifo_q[wr_ptr_q] <= bus.app_rd_data;
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = fifo_q[rd_ptr_q];
    assign bus.app_en       = app_en_q;
    assign bus.app_wdf_wren = app_wdf_wren_q;
    assign bus.app_wdf_end  = app_wdf_end_q;
    assign bus.app_cmd      = app_cmd_q;
    assign bus.app_addr     = app_addr_q;
    assign bus.app_wdf_data = app_wdf_data_q;
    assign bus.app_wdf_mask = app_wdf_mask_q;
    assign bus.busy         = busy_q;
    assign bus.err_sticky   = err_sticky_q;
endmodule
